// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the pipeline stage register:
// stall-bus encoding, delay-slot flags, default bubble payload.
package pipe_stage_reg_pkg;

   localparam int unsigned STALL_W = 6;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic IN_DELAY_SLOT     = 1'b1;
   localparam logic NOT_IN_DELAY_SLOT = 1'b0;

   localparam int unsigned NOP_PAYLOAD_W = 64;
   localparam logic [NOP_PAYLOAD_W-1:0] NOP_PAYLOAD = '0;

   typedef enum logic [1:0] {
      ACT_HOLD    = 2'd0,
      ACT_ADVANCE = 2'd1,
      ACT_BUBBLE  = 2'd2,
      ACT_FLUSH   = 2'd3
   } stage_act_e;

   // flush beats every stall combination; a stopped stage feeding a running
   // stage must inject a bubble so the same instruction is not issued twice
   function automatic stage_act_e decode_act(input logic flush,
                                             input logic s,
                                             input logic n);
      stage_act_e act;
      if (flush)
         act = ACT_FLUSH;
      else if (s == STOP && n == NO_STOP)
         act = ACT_BUBBLE;
      else if (s == NO_STOP)
         act = ACT_ADVANCE;
      else
         act = ACT_HOLD;
      return act;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear and async reset.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/bubble/flush handling, delay-slot
// tracking and saturating performance counters.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned           PAYLOAD_W = 64,
   parameter int unsigned           STAGE     = 2,
   parameter logic [PAYLOAD_W-1:0]  NOP_VAL   = PAYLOAD_W'(NOP_PAYLOAD),
   parameter int unsigned           CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [STALL_W-1:0]   stall,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic                 in_delayslot,
   input  logic                 next_delayslot_i,
   input  logic                 cnt_clr,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic                 out_delayslot,
   output logic                 delayslot_o,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     bubble_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   if (STAGE > 4) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE must be in 0..4");
   end

   logic       s_stop;
   logic       n_stop;
   stage_act_e act_c;
   logic       unused_stall;

   assign s_stop       = stall[STAGE];
   assign n_stop       = stall[STAGE+1];
   assign unused_stall = ^stall;

   always_comb begin
      act_c = ACT_HOLD;
      act_c = decode_act(flush, s_stop, n_stop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_payload   <= NOP_VAL;
         out_delayslot <= NOT_IN_DELAY_SLOT;
         delayslot_o   <= NOT_IN_DELAY_SLOT;
      end else begin
         case (act_c)
            ACT_FLUSH, ACT_BUBBLE: begin
               out_valid     <= 1'b0;
               out_payload   <= NOP_VAL;
               out_delayslot <= NOT_IN_DELAY_SLOT;
               delayslot_o   <= NOT_IN_DELAY_SLOT;
            end
            ACT_ADVANCE: begin
               out_valid     <= in_valid;
               out_payload   <= in_payload;
               out_delayslot <= in_delayslot;
               delayslot_o   <= next_delayslot_i;
            end
            default: ;
         endcase
      end
   end

   // stall time is counted even while bubbling; flushed edges are not stalls
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (s_stop == STOP && !flush),
      .clr (cnt_clr),
      .cnt (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (act_c == ACT_BUBBLE),
      .clr (cnt_clr),
      .cnt (bubble_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (act_c == ACT_FLUSH),
      .clr (cnt_clr),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (STAGE=2, CNT_W=4,
// non-zero bubble payload so bubbles are distinguishable from zero data).
module tb_pipe_stage_reg;

   localparam int unsigned PW = 64;
   localparam int unsigned CW = 4;
   localparam logic [PW-1:0] NOP = 64'hDEAD_BEEF_0000_0BAD;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    stall;
   logic          flush;
   logic          in_valid;
   logic [PW-1:0] in_payload;
   logic          in_delayslot;
   logic          next_delayslot_i;
   logic          cnt_clr;
   logic          out_valid;
   logic [PW-1:0] out_payload;
   logic          out_delayslot;
   logic          delayslot_o;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] bubble_cnt;
   logic [CW-1:0] flush_cnt;

   int errors = 0;
   int checks = 0;

   pipe_stage_reg #(
      .PAYLOAD_W (PW),
      .STAGE     (2),
      .NOP_VAL   (NOP),
      .CNT_W     (CW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .flush            (flush),
      .in_valid         (in_valid),
      .in_payload       (in_payload),
      .in_delayslot     (in_delayslot),
      .next_delayslot_i (next_delayslot_i),
      .cnt_clr          (cnt_clr),
      .out_valid        (out_valid),
      .out_payload      (out_payload),
      .out_delayslot    (out_delayslot),
      .delayslot_o      (delayslot_o),
      .stall_cnt        (stall_cnt),
      .bubble_cnt       (bubble_cnt),
      .flush_cnt        (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag, input logic v, input logic [PW-1:0] p,
                           input logic ds, input logic dso);
      chk({tag, ".valid"}, 64'(out_valid), 64'(v));
      chk({tag, ".payload"}, out_payload, p);
      chk({tag, ".ds"}, 64'(out_delayslot), 64'(ds));
      chk({tag, ".dso"}, 64'(delayslot_o), 64'(dso));
   endtask

   task automatic chk_cnts(input string tag, input int s, input int b, input int f);
      chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(s));
      chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(b));
      chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(f));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_payload = '0;
      in_delayslot = 1'b0; next_delayslot_i = 1'b0; cnt_clr = 1'b0;
      #3;
      chk_regs("reset", 1'b0, NOP, 1'b0, 1'b0);
      chk_cnts("reset", 0, 0, 0);
      step();
      rst = 1'b0;

      // plain advance
      in_valid = 1'b1; in_payload = 64'hA5A5_0000_0000_0001;
      step();
      chk_regs("advance", 1'b1, 64'hA5A5_0000_0000_0001, 1'b0, 1'b0);
      chk_cnts("advance", 0, 0, 0);

      // S=1, N=0 -> bubble
      stall = 6'b000111;
      step();
      chk_regs("bubble", 1'b0, NOP, 1'b0, 1'b0);
      chk_cnts("bubble", 1, 1, 0);

      // capture with delay-slot flags while clearing counters
      stall = 6'b000000; cnt_clr = 1'b1; in_payload = 64'h1234_5678_9ABC_DEF0;
      in_delayslot = 1'b1; next_delayslot_i = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk_regs("capture", 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
      chk_cnts("capture", 0, 0, 0);

      // S=1, N=1 -> hold for three edges while inputs change
      stall = 6'b001111; in_valid = 1'b0; in_payload = 64'hFFFF_0000_FFFF_0000;
      in_delayslot = 1'b0; next_delayslot_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_regs("hold", 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
      end
      chk_cnts("hold", 3, 0, 0);

      // flush overrides S=1, N=1
      flush = 1'b1;
      step();
      chk_regs("flush_ss", 1'b0, NOP, 1'b0, 1'b0);
      chk_cnts("flush_ss", 3, 0, 1);

      // flush overrides advance
      stall = 6'b000000; in_valid = 1'b1; in_payload = 64'h0000_0000_0000_00AA;
      step();
      chk_regs("flush_adv", 1'b0, NOP, 1'b0, 1'b0);
      chk_cnts("flush_adv", 3, 0, 2);
      flush = 1'b0;

      // S=0, N=1 -> advance
      stall = 6'b001000; in_payload = 64'h0000_0000_0000_00BB;
      step();
      chk_regs("adv_nstop", 1'b1, 64'h0000_0000_0000_00BB, 1'b0, 1'b0);
      chk_cnts("adv_nstop", 3, 0, 2);

      // saturation: 20 bubble edges on a 4-bit counter
      stall = 6'b000111; cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk_cnts("clr_over_bubble", 0, 0, 0);
      for (int i = 0; i < 20; i++) step();
      chk_cnts("saturate", 15, 15, 0);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk_cnts("clr_sat", 0, 0, 0);

      // async reset during hold
      stall = 6'b000000; in_payload = 64'h0000_0000_0000_00CC;
      step();
      stall = 6'b001111;
      step();
      chk_regs("pre_rst_hold", 1'b1, 64'h0000_0000_0000_00CC, 1'b0, 1'b0);
      chk_cnts("pre_rst_hold", 1, 0, 0);
      rst = 1'b1;
      #1;
      chk_regs("async_rst", 1'b0, NOP, 1'b0, 1'b0);
      chk_cnts("async_rst", 0, 0, 0);
      rst = 1'b0;
      #1;

      // first edge after release advances delay-slot flags
      stall = 6'b000000; in_delayslot = 1'b1; next_delayslot_i = 1'b1;
      in_payload = 64'h0000_0000_0000_00DD;
      step();
      chk_regs("post_rst_adv", 1'b1, 64'h0000_0000_0000_00DD, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
